adc_ltc2308_scan: RTL and testbench

- Parametrised successor to the single-shot LTC2308 controller.
- Scans an 8-bit channel enable mask in one-shot or continuous mode, with optional per-channel power-of-two averaging and unipolar/bipolar coding.
- Handles the LTC2308 one-frame config pipeline, so each output result carries the channel it belongs to.
- Sits between the 40 MHz ADC clock domain logic and the ADC pins; feeds a result stream to downstream FIFO/UART logic.

---
 rtl/adc_ltc2308_scan.sv | 243 ++++++++++++++++++++++++
 tb/tb_adc_ltc2308_scan.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_ltc2308_scan.sv
// LTC2308 scanning controller: walks an enabled-channel mask in one-shot or
// continuous passes, keeps track of the one-frame config pipeline of the
// ADC, optionally averages 2^AVG_LOG2 samples per channel and emits one
// result strobe (data + channel) per channel per pass.
module adc_ltc2308_scan #(
  parameter int SCK_HALF    = 2,
  parameter int T_CONV_CYC  = 64,
  parameter int CONVST_HIGH = 2,
  parameter int AVG_LOG2    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic        continuous,
  input  logic [7:0]  ch_mask,
  input  logic        unipolar,
  output logic        ready,
  output logic        result_valid,
  output logic [11:0] result_data,
  output logic [2:0]  result_channel,
  output logic        CONVST,
  output logic        SCK,
  output logic        SDI,
  input  logic        SDO
);

  localparam int ACC_W = 12 + AVG_LOG2;
  localparam int REP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam int CYC_W = $clog2(T_CONV_CYC + 1);
  localparam int HC_W  = (SCK_HALF > 1) ? $clog2(SCK_HALF) : 1;

  localparam logic [REP_W-1:0] REP_LAST      = REP_W'((1 << AVG_LOG2) - 1);
  localparam logic [CYC_W-1:0] CNV_HI_LAST   = CYC_W'(CONVST_HIGH - 1);
  localparam logic [CYC_W-1:0] CNV_WAIT_LAST = CYC_W'(T_CONV_CYC - 1);
  localparam logic [HC_W-1:0]  HALF_LAST     = HC_W'(SCK_HALF - 1);

  typedef enum logic [2:0] {
    IDLE,
    CNV_HI,
    CNV_WAIT,
    SHIFT,
    GAP
  } state_t;

  state_t state, state_next;

  // Frame timing and serial interface
  logic [CYC_W-1:0] cyc;
  logic [HC_W-1:0]  half_cnt;
  logic             sck_hi;
  logic [3:0]       bit_idx;
  logic [11:0]      shift_reg;
  logic             convst_q;

  // Scan context latched at start
  logic [7:0]       mask_l;
  logic             uni_l;
  logic             cont_l;
  logic             stop_l;

  // Channel/repeat being configured this frame and the one being read back
  logic [2:0]       cfg_ch;
  logic [REP_W-1:0] cfg_rep;
  logic [2:0]       data_ch;
  logic [REP_W-1:0] data_rep;
  logic             data_valid;

  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] acc_sum;
  logic signed [ACC_W-1:0] avg_val;

  logic       start_ok;
  logic       shift_done;
  logic       pass_end;
  logic [5:0] cfg_word;
  logic [2:0] sdi_sel;

  // Next enabled channel after c, wrapping; returns c when it is the only one
  function automatic logic [2:0] next_ch(input logic [7:0] m, input logic [2:0] c);
    logic [2:0] r;
    logic [2:0] idx;
    logic       found;
    r     = c;
    found = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = c + 3'(i);
      if (!found && m[idx]) begin
        r     = idx;
        found = 1'b1;
      end
    end
    return r;
  endfunction

  // Lowest enabled channel
  function automatic logic [2:0] first_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Highest enabled channel
  function automatic logic [2:0] last_ch(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Decode conditions used by both the FSM and the datapath
  always_comb begin
    start_ok   = start && (ch_mask != 8'd0);
    shift_done = sck_hi && (half_cnt == HALF_LAST) && (bit_idx == 4'd11);
    pass_end   = data_valid && (data_rep == REP_LAST) && (data_ch == last_ch(mask_l));
    sample_ext = uni_l ? ACC_W'(shift_reg) : ACC_W'($signed(shift_reg));
    acc_sum    = acc + sample_ext;
    avg_val    = uni_l ? (acc_sum >> AVG_LOG2) : (acc_sum >>> AVG_LOG2);
  end

  // FSM state register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // FSM next-state logic
  always_comb begin
    state_next = state;
    case (state)
      IDLE:     if (start_ok) state_next = CNV_HI;
      CNV_HI:   if (cyc == CNV_HI_LAST) state_next = CNV_WAIT;
      CNV_WAIT: if (cyc == CNV_WAIT_LAST) state_next = SHIFT;
      SHIFT:    if (shift_done) state_next = GAP;
      GAP:      state_next = (pass_end && (stop_l || stop || !cont_l)) ? IDLE : CNV_HI;
      default:  state_next = IDLE;
    endcase
  end

  // Conversion timer, SCK generation and SDO capture on the SCK rising edge
  always_ff @(posedge clock) begin
    if (!reset) begin
      cyc       <= '0;
      half_cnt  <= '0;
      sck_hi    <= 1'b0;
      bit_idx   <= 4'd0;
      shift_reg <= 12'd0;
      convst_q  <= 1'b0;
    end else begin
      convst_q <= (state_next == CNV_HI);
      if (state == CNV_HI || state == CNV_WAIT) cyc <= cyc + 1'b1;
      else                                      cyc <= '0;
      if (state == SHIFT) begin
        if (half_cnt == HALF_LAST) begin
          half_cnt <= '0;
          sck_hi   <= !sck_hi;
          if (!sck_hi) shift_reg <= {shift_reg[10:0], SDO};
          else         bit_idx   <= bit_idx + 4'd1;
        end else begin
          half_cnt <= half_cnt + 1'b1;
        end
      end else begin
        half_cnt <= '0;
        sck_hi   <= 1'b0;
        bit_idx  <= 4'd0;
      end
    end
  end

  // Scan sequencing: start latch, stop latch, channel pipeline and averaging
  always_ff @(posedge clock) begin
    if (!reset) begin
      mask_l         <= 8'd0;
      uni_l          <= 1'b0;
      cont_l         <= 1'b0;
      stop_l         <= 1'b0;
      cfg_ch         <= 3'd0;
      cfg_rep        <= '0;
      data_ch        <= 3'd0;
      data_rep       <= '0;
      data_valid     <= 1'b0;
      acc            <= '0;
      result_valid   <= 1'b0;
      result_data    <= 12'd0;
      result_channel <= 3'd0;
    end else begin
      result_valid <= 1'b0;
      if (state == IDLE) begin
        if (start_ok) begin
          mask_l     <= ch_mask;
          uni_l      <= unipolar;
          cont_l     <= continuous;
          stop_l     <= 1'b0;
          cfg_ch     <= first_ch(ch_mask);
          cfg_rep    <= '0;
          data_valid <= 1'b0;
          acc        <= '0;
        end
      end else if (stop) begin
        stop_l <= 1'b1;
      end
      if (state == GAP) begin
        if (data_valid) begin
          if (data_rep == REP_LAST) begin
            result_valid   <= 1'b1;
            result_data    <= avg_val[11:0];
            result_channel <= data_ch;
            acc            <= '0;
          end else begin
            acc <= acc_sum;
          end
        end
        data_ch    <= cfg_ch;
        data_rep   <= cfg_rep;
        data_valid <= 1'b1;
        if (cfg_rep == REP_LAST) begin
          cfg_rep <= '0;
          cfg_ch  <= next_ch(mask_l, cfg_ch);
        end else begin
          cfg_rep <= cfg_rep + 1'b1;
        end
      end
    end
  end

  // Pin outputs; SDI walks the 6-bit config word MSB first, then zeros
  always_comb begin
    cfg_word = {1'b1, cfg_ch[0], cfg_ch[2], cfg_ch[1], uni_l, 1'b0};
    sdi_sel  = 3'd5 - bit_idx[2:0];
    SDI      = 1'b0;
    if (state == SHIFT && bit_idx < 4'd6) SDI = cfg_word[sdi_sel];
    ready  = (state == IDLE);
    CONVST = convst_q;
    SCK    = sck_hi;
  end

endmodule

// File: tb/tb_adc_ltc2308_scan.sv
// Scoreboard bench for adc_ltc2308_scan: two instances (no averaging and
// 4-sample averaging), each driven by a small LTC2308 behavioural model.
module tb_adc_ltc2308_scan;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  // Instance A: default parameters
  logic        a_reset, a_start, a_stop, a_continuous, a_unipolar;
  logic [7:0]  a_ch_mask;
  logic        a_ready, a_result_valid;
  logic [11:0] a_result_data;
  logic [2:0]  a_result_channel;
  logic        a_CONVST, a_SCK, a_SDI;
  logic        a_SDO = 1'b0;

  // Instance B: AVG_LOG2 = 2
  logic        b_reset, b_start, b_stop, b_continuous, b_unipolar;
  logic [7:0]  b_ch_mask;
  logic        b_ready, b_result_valid;
  logic [11:0] b_result_data;
  logic [2:0]  b_result_channel;
  logic        b_CONVST, b_SCK, b_SDI;
  logic        b_SDO = 1'b0;

  adc_ltc2308_scan dut_a (
    .clock(clock), .reset(a_reset), .start(a_start), .stop(a_stop),
    .continuous(a_continuous), .ch_mask(a_ch_mask), .unipolar(a_unipolar),
    .ready(a_ready), .result_valid(a_result_valid), .result_data(a_result_data),
    .result_channel(a_result_channel), .CONVST(a_CONVST), .SCK(a_SCK),
    .SDI(a_SDI), .SDO(a_SDO)
  );

  adc_ltc2308_scan #(.AVG_LOG2(2)) dut_b (
    .clock(clock), .reset(b_reset), .start(b_start), .stop(b_stop),
    .continuous(b_continuous), .ch_mask(b_ch_mask), .unipolar(b_unipolar),
    .ready(b_ready), .result_valid(b_result_valid), .result_data(b_result_data),
    .result_channel(b_result_channel), .CONVST(b_CONVST), .SCK(b_SCK),
    .SDI(b_SDI), .SDO(b_SDO)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  // Expected {channel, data} results, pushed by stimulus, popped by monitors
  logic [14:0] exp_a[$];
  logic [14:0] exp_b[$];

  // ADC model state
  logic [11:0] chan_val[8];
  logic [11:0] b_samp_q[$];
  logic [11:0] a_cfg_log[$];
  logic [11:0] a_word_sr = 12'd0, a_word_last = 12'd0, a_conv = 12'd0;
  logic [11:0] b_word_sr = 12'd0, b_word_last = 12'd0, b_conv = 12'd0;
  logic        a_convst_d = 1'b0, a_sck_d = 1'b0, b_convst_d = 1'b0, b_sck_d = 1'b0;
  int a_sdo_idx = 11, b_sdo_idx = 11;
  int a_conv_cnt = 0, b_conv_cnt = 0;
  int a_sck_rises = 0, b_sck_rises = 0;
  int cyc_now = 0;
  int a_rise_t = 0, a_frame_len = 0, a_hi_len = 0, a_first_sck = 0;
  int a_sck_period = 0, a_last_sck_t = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    check_cnt++;
    if (actual === expected) pass_cnt++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  task automatic flagUnexpected(input string name, input logic [14:0] actual);
    check_cnt++;
    $display("[TB] FAIL %s: got result_valid=1 {ch,data}=0x%0h, expected no result", name, actual);
  endtask

  task automatic applyStimulus(input bit use_b, input logic [7:0] mask,
                               input logic cont, input logic uni);
    if (use_b) begin
      b_ch_mask = mask; b_continuous = cont; b_unipolar = uni; b_start = 1'b1;
    end else begin
      a_ch_mask = mask; a_continuous = cont; a_unipolar = uni; a_start = 1'b1;
    end
    @(negedge clock);
    a_start = 1'b0;
    b_start = 1'b0;
  endtask

  task automatic waitReady(input bit use_b, input int limit);
    int n;
    n = 0;
    while (((use_b ? b_ready : a_ready) == 1'b0) && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput(use_b ? "b_ready_after_scan" : "a_ready_after_scan",
                use_b ? b_ready : a_ready, 1);
  endtask

  task automatic waitConvA(input int count, input int limit);
    int n;
    n = 0;
    while (a_conv_cnt < count && n < limit) begin
      @(negedge clock);
      n++;
    end
    checkOutput("a_conv_reached", (a_conv_cnt >= count) ? 1 : 0, 1);
  endtask

  // ADC model A: channel chosen by the config word of the previous frame
  always @(negedge clock) begin
    cyc_now++;
    if (a_CONVST && !a_convst_d) begin
      a_frame_len = cyc_now - a_rise_t;
      a_rise_t    = cyc_now;
      a_hi_len    = 0;
      a_sck_rises = 0;
      a_conv_cnt++;
      a_conv    = chan_val[{a_word_last[9], a_word_last[8], a_word_last[10]}];
      a_sdo_idx = 11;
      a_SDO     = a_conv[11];
      a_word_sr = 12'd0;
    end
    if (a_CONVST) a_hi_len++;
    if (a_SCK && !a_sck_d) begin
      a_word_sr = {a_word_sr[10:0], a_SDI};
      a_sck_rises++;
      if (a_sck_rises == 1) a_first_sck = cyc_now - a_rise_t;
      if (a_sck_rises == 2) a_sck_period = cyc_now - a_last_sck_t;
      a_last_sck_t = cyc_now;
      if (a_sck_rises == 12) begin
        a_word_last = a_word_sr;
        a_cfg_log.push_back(a_word_sr);
      end
    end
    if (!a_SCK && a_sck_d) begin
      if (a_sdo_idx > 0) a_sdo_idx--;
      a_SDO = a_conv[a_sdo_idx];
    end
    a_convst_d = a_CONVST;
    a_sck_d    = a_SCK;
  end

  // ADC model B: each conversion returns the next queued sample
  always @(negedge clock) begin
    if (b_CONVST && !b_convst_d) begin
      b_conv_cnt++;
      if (b_samp_q.size() > 0) b_conv = b_samp_q.pop_front();
      else                     b_conv = 12'h000;
      b_sdo_idx   = 11;
      b_SDO       = b_conv[11];
      b_word_sr   = 12'd0;
      b_sck_rises = 0;
    end
    if (b_SCK && !b_sck_d) begin
      b_word_sr = {b_word_sr[10:0], b_SDI};
      b_sck_rises++;
      if (b_sck_rises == 12) b_word_last = b_word_sr;
    end
    if (!b_SCK && b_sck_d) begin
      if (b_sdo_idx > 0) b_sdo_idx--;
      b_SDO = b_conv[b_sdo_idx];
    end
    b_convst_d = b_CONVST;
    b_sck_d    = b_SCK;
  end

  // Result monitors
  always @(negedge clock) begin
    logic [14:0] e;
    if (a_result_valid) begin
      if (exp_a.size() == 0) flagUnexpected("a_unexpected_result", {a_result_channel, a_result_data});
      else begin
        e = exp_a.pop_front();
        checkOutput("a_result", {a_result_channel, a_result_data}, e);
      end
    end
    if (b_result_valid) begin
      if (exp_b.size() == 0) flagUnexpected("b_unexpected_result", {b_result_channel, b_result_data});
      else begin
        e = exp_b.pop_front();
        checkOutput("b_result", {b_result_channel, b_result_data}, e);
      end
    end
  end

  // Watchdog
  initial begin
    repeat (30000) @(posedge clock);
    $display("[TB] FAIL watchdog: got no completion within 30000 cycles, expected $finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Main directed sequence
  initial begin
    logic [11:0] w;
    chan_val[0] = 12'hA5C; chan_val[1] = 12'h456; chan_val[2] = 12'h123;
    chan_val[3] = 12'h0F0; chan_val[4] = 12'h0F0; chan_val[5] = 12'h0F0;
    chan_val[6] = 12'h0F0; chan_val[7] = 12'h0F0;
    a_reset = 1'b0; a_start = 1'b1; a_stop = 1'b0; a_continuous = 1'b0;
    a_ch_mask = 8'h01; a_unipolar = 1'b1;
    b_reset = 1'b0; b_start = 1'b0; b_stop = 1'b0; b_continuous = 1'b0;
    b_ch_mask = 8'h00; b_unipolar = 1'b0;

    // Reset held with start=1: outputs at reset values
    repeat (5) begin
      @(negedge clock);
      checkOutput("reset_outputs",
                  {a_ready, a_CONVST, a_SCK, a_SDI, a_result_valid, a_result_channel, a_result_data},
                  {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 12'd0});
    end
    a_reset = 1'b1;
    exp_a.push_back({3'd0, 12'hA5C});
    @(negedge clock);
    checkOutput("start_after_reset", {a_ready, a_CONVST}, 2'b01);
    a_start = 1'b0;
    waitReady(0, 1000);

    // One-shot over ch0 and ch2, unipolar, with frame timing
    @(negedge clock);
    a_conv_cnt = 0;
    a_cfg_log.delete();
    exp_a.push_back({3'd0, 12'hA5C});
    exp_a.push_back({3'd2, 12'h123});
    applyStimulus(0, 8'h05, 1'b0, 1'b1);
    checkOutput("a_busy_after_start", a_ready, 0);
    waitReady(0, 1000);
    checkOutput("oneshot_convst_count", a_conv_cnt, 3);
    checkOutput("oneshot_cfg_count", a_cfg_log.size(), 3);
    for (int i = 0; i < 3; i++) begin
      w = (i < a_cfg_log.size()) ? a_cfg_log[i] : 12'hFFF;
      checkOutput("oneshot_sdi_word", w,
                  (i == 1) ? 12'b100110_000000 : 12'b100010_000000);
    end
    checkOutput("convst_high_cycles", a_hi_len, 2);
    checkOutput("first_sck_delay", a_first_sck, 66);
    checkOutput("sck_pulses", a_sck_rises, 12);
    checkOutput("sck_period", a_sck_period, 4);
    checkOutput("frame_length", a_frame_len, 113);

    // Continuous over ch0/ch1, stop during second pass
    a_conv_cnt = 0;
    exp_a.push_back({3'd0, 12'hA5C});
    exp_a.push_back({3'd1, 12'h456});
    exp_a.push_back({3'd0, 12'hA5C});
    exp_a.push_back({3'd1, 12'h456});
    applyStimulus(0, 8'h03, 1'b1, 1'b1);
    waitConvA(4, 2000);
    a_stop = 1'b1;
    @(negedge clock);
    a_stop = 1'b0;
    waitReady(0, 1000);
    checkOutput("continuous_convst_count", a_conv_cnt, 5);

    // Reset pulse during the SHIFT of a data frame
    a_conv_cnt = 0;
    applyStimulus(0, 8'h01, 1'b0, 1'b1);
    waitConvA(2, 1000);
    begin
      int n;
      n = 0;
      while (a_SCK == 1'b0 && n < 200) begin
        @(negedge clock);
        n++;
      end
    end
    checkOutput("sck_seen_before_reset", a_SCK, 1);
    a_reset = 1'b0;
    @(negedge clock);
    a_reset = 1'b1;
    checkOutput("midshift_reset_outputs", {a_SCK, a_CONVST, a_ready, a_result_valid}, 4'b0010);
    repeat (150) @(negedge clock);
    checkOutput("no_scan_after_reset", a_conv_cnt, 2);

    // Start with an empty mask is ignored
    a_ch_mask = 8'h00;
    a_start = 1'b1;
    repeat (10) begin
      @(negedge clock);
      checkOutput("zero_mask_ready", a_ready, 1);
    end
    a_start = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("zero_mask_no_convst", a_conv_cnt, 2);

    // Averaging instance: bipolar ch3, two scans
    b_reset = 1'b1;
    @(negedge clock);
    b_conv_cnt = 0;
    b_samp_q = '{12'h000, 12'h7FF, 12'h801, 12'h002, 12'h000};
    exp_b.push_back({3'd3, 12'h000});
    applyStimulus(1, 8'h08, 1'b0, 1'b0);
    waitReady(1, 1500);
    checkOutput("avg_convst_count", b_conv_cnt, 5);
    checkOutput("avg_samples_consumed", b_samp_q.size(), 0);
    checkOutput("avg_sdi_word", b_word_last, 12'b110100_000000);

    @(negedge clock);
    b_conv_cnt = 0;
    b_samp_q = '{12'h555, 12'hFFF, 12'hFFF, 12'hFFE, 12'hFFE};
    exp_b.push_back({3'd3, 12'hFFE});
    applyStimulus(1, 8'h08, 1'b0, 1'b0);
    waitReady(1, 1500);
    checkOutput("avg2_convst_count", b_conv_cnt, 5);

    repeat (5) @(negedge clock);
    checkOutput("a_expected_drained", exp_a.size(), 0);
    checkOutput("b_expected_drained", exp_b.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
